// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: job/beat handshake and skewed edge outputs of systolic_feeder.
// acc_clr_n exists only when FEEDER_ACC_CLR_EN is defined.
interface systolic_feeder_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N = 4,
   parameter int K_MAX = 16
);
   logic start;
   logic [$clog2(K_MAX+1)-1:0] k_len;
   logic in_valid;
   logic in_ready;
   logic [N*DATA_WIDTH-1:0] in_a;
   logic [N*DATA_WIDTH-1:0] in_b;
   logic [N*DATA_WIDTH-1:0] a_out;
   logic [N*DATA_WIDTH-1:0] b_out;
   logic busy;
   logic done;
`ifdef FEEDER_ACC_CLR_EN
   logic acc_clr_n;
`endif
   modport master (
      output start, k_len, in_valid, in_a, in_b,
`ifdef FEEDER_ACC_CLR_EN
      input acc_clr_n,
`endif
      input in_ready, a_out, b_out, busy, done
   );
   modport slave (
      input start, k_len, in_valid, in_a, in_b,
`ifdef FEEDER_ACC_CLR_EN
      output acc_clr_n,
`endif
      output in_ready, a_out, b_out, busy, done
   );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one A/B job and feeds it skewed into an N x N systolic array.
// FEEDER_ACC_CLR_EN adds acc_clr_n, pulsed low in the first LOAD cycle.
module systolic_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int N = 4,
   parameter int K_MAX = 16
) (
   input logic clk,
   input logic rst_n,
   systolic_feeder_if.slave bus
);
   localparam int DW = DATA_WIDTH;
   localparam int KW = $clog2(K_MAX + 1);
   localparam int CW = $clog2(K_MAX + 2 * N + 1);
   localparam int AW = K_MAX > 1 ? $clog2(K_MAX) : 1;
   typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt, t_nxt;
   logic [KW-1:0] klen, klen_in;
   logic feed_nxt, beat;
   logic [N*DW-1:0] a_buf [K_MAX];
   logic [N*DW-1:0] b_buf [K_MAX];
   logic [N*DW-1:0] a_q, b_q, a_nxt, b_nxt;
   assign klen_in = (bus.k_len > KW'(K_MAX)) ? KW'(K_MAX) : bus.k_len;
   assign beat = state == LOAD && bus.in_valid;
   always_comb begin
      state_nxt = state;
      cnt_nxt = cnt;
      feed_nxt = 1'b0;
      t_nxt = '0;
      case (state)
         IDLE: if (bus.start) begin
            state_nxt = (klen_in == '0) ? DONE : LOAD;
            cnt_nxt = '0;
         end
         LOAD: if (beat) begin
            if (cnt == CW'(klen) - CW'(1)) begin
               state_nxt = FEED;
               cnt_nxt = '0;
               feed_nxt = 1'b1;
            end else cnt_nxt = cnt + CW'(1);
         end
         FEED: if (cnt == CW'(klen) + CW'(N) - CW'(2)) begin
            state_nxt = DRAIN;
            cnt_nxt = '0;
         end else begin
            cnt_nxt = cnt + CW'(1);
            feed_nxt = 1'b1;
            t_nxt = cnt + CW'(1);
         end
         DRAIN: if (cnt == CW'(2 * N - 1)) begin
            state_nxt = DONE;
            cnt_nxt = '0;
         end else cnt_nxt = cnt + CW'(1);
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end
   // t-i wraps to a value above K_MAX+N when t<i, so the idx<klen test also covers t<i
   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [CW-1:0] idx;
      logic hit;
      logic [N*DW-1:0] aw, bw;
      assign idx = t_nxt - CW'(i);
      assign hit = feed_nxt && idx < CW'(klen);
      assign aw = (state == LOAD && idx == cnt) ? bus.in_a : a_buf[idx[AW-1:0]];
      assign bw = (state == LOAD && idx == cnt) ? bus.in_b : b_buf[idx[AW-1:0]];
      assign a_nxt[i*DW +: DW] = hit ? aw[i*DW +: DW] : '0;
      assign b_nxt[i*DW +: DW] = hit ? bw[i*DW +: DW] : '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         klen <= '0;
         a_q <= '0;
         b_q <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         a_q <= a_nxt;
         b_q <= b_nxt;
         if (state == IDLE && bus.start) klen <= klen_in;
      end
   end
   always_ff @(posedge clk) begin
      if (beat) begin
         a_buf[cnt[AW-1:0]] <= bus.in_a;
         b_buf[cnt[AW-1:0]] <= bus.in_b;
      end
   end
`ifdef FEEDER_ACC_CLR_EN
   logic acc_clr_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_clr_q <= 1'b1;
      else acc_clr_q <= !(state == IDLE && state_nxt == LOAD);
   end
   assign bus.acc_clr_n = acc_clr_q;
`endif
   assign bus.in_ready = state == LOAD;
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   assign bus.a_out = a_q;
   assign bus.b_out = b_q;
endmodule
